// File: rtl/shared_mem_arbiter.sv
// Request stage between two cores and the dual-core data memory. It registers private accesses
// directly and serialises shared-bank accesses, using a round-robin priority on conflicts.
module shared_mem_arbiter #(
  parameter int unsigned Ncores = 2,
  parameter int unsigned Lmem   = 8,
  parameter int unsigned TAM    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:Ncores-1] coreLoad,
  input  logic [0:Ncores-1] coreWrite,
  input  logic [0:TAM-1]    coreADDR0,
  input  logic [0:TAM-1]    coreADDR1,
  input  logic [0:TAM-1]    coreIN0,
  input  logic [0:TAM-1]    coreIN1,
  output logic [0:Ncores-1] stall,
  output logic [0:Ncores-1] memLoad,
  output logic [0:Ncores-1] memWrite,
  output logic [0:TAM-1]    memADDR0,
  output logic [0:TAM-1]    memADDR1,
  output logic [0:TAM-1]    memIN0,
  output logic [0:TAM-1]    memIN1,
  output logic              errFlag
);

  // Bank select is the address bit of weight 2**Lmem; vectors are MSB-first ([0:TAM-1]).
  localparam int unsigned BankBit = TAM - 1 - Lmem;

  logic [0:Ncores-1] active;
  logic [0:Ncores-1] shared_req;
  logic [0:Ncores-1] accept;
  logic              conflict;
  logic              prio_q, prio_d;
  logic              err_q, err_d;

  logic [0:Ncores-1] mem_load_q, mem_write_q;
  logic [0:TAM-1]    mem_addr0_q, mem_addr1_q;
  logic [0:TAM-1]    mem_in0_q, mem_in1_q;

  always_comb begin
    active        = coreLoad | coreWrite;
    shared_req[0] = active[0] & coreADDR0[BankBit];
    shared_req[1] = active[1] & coreADDR1[BankBit];
    conflict      = shared_req[0] & shared_req[1];
    // On a conflict only the core named by prio_q gets through.
    accept[0]     = active[0] & ~(conflict & prio_q);
    accept[1]     = active[1] & ~(conflict & ~prio_q);
    prio_d        = conflict ? ~prio_q : prio_q;
    err_d         = err_q | (|(coreLoad & coreWrite));
    stall         = rst ? '0 : (active & ~accept);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_load_q  <= '0;
      mem_write_q <= '0;
      mem_addr0_q <= '0;
      mem_addr1_q <= '0;
      mem_in0_q   <= '0;
      mem_in1_q   <= '0;
    end else begin
      prio_q <= prio_d;
      err_q  <= err_d;
      // Load together with write is demoted to a plain write.
      mem_load_q[0]  <= accept[0] & coreLoad[0] & ~coreWrite[0];
      mem_load_q[1]  <= accept[1] & coreLoad[1] & ~coreWrite[1];
      mem_write_q[0] <= accept[0] & coreWrite[0];
      mem_write_q[1] <= accept[1] & coreWrite[1];
      if (accept[0]) begin
        mem_addr0_q <= coreADDR0;
        mem_in0_q   <= coreIN0;
      end
      if (accept[1]) begin
        mem_addr1_q <= coreADDR1;
        mem_in1_q   <= coreIN1;
      end
    end
  end

  assign memLoad  = mem_load_q;
  assign memWrite = mem_write_q;
  assign memADDR0 = mem_addr0_q;
  assign memADDR1 = mem_addr1_q;
  assign memIN0   = mem_in0_q;
  assign memIN1   = mem_in1_q;
  assign errFlag  = err_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Scoreboard bench for shared_mem_arbiter: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_shared_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:1]  coreLoad = '0, coreWrite = '0;
  logic [0:15] coreADDR0 = '0, coreADDR1 = '0, coreIN0 = '0, coreIN1 = '0;
  logic [0:1]  stall, memLoad, memWrite;
  logic [0:15] memADDR0, memADDR1, memIN0, memIN1;
  logic        errFlag;

  always #5 clk = ~clk;

  shared_mem_arbiter #(.Ncores(2), .Lmem(8), .TAM(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .coreLoad (coreLoad),
    .coreWrite(coreWrite),
    .coreADDR0(coreADDR0),
    .coreADDR1(coreADDR1),
    .coreIN0  (coreIN0),
    .coreIN1  (coreIN1),
    .stall    (stall),
    .memLoad  (memLoad),
    .memWrite (memWrite),
    .memADDR0 (memADDR0),
    .memADDR1 (memADDR1),
    .memIN0   (memIN0),
    .memIN1   (memIN1),
    .errFlag  (errFlag)
  );

  typedef struct {
    string       tag;
    logic [0:1]  stall, ml, mw;
    logic [0:15] a0, i0, a1, i1;
    logic        err;
    logic        cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   wr0_cnt = 0;
  int   wr1_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs; mem* expectations describe the edge just taken.
  task automatic step(input string tag, input logic r, input logic [0:1] ld, input logic [0:1] wr,
                      input logic [0:15] ca0, input logic [0:15] cd0,
                      input logic [0:15] ca1, input logic [0:15] cd1,
                      input logic [0:1] es, input logic [0:1] eml, input logic [0:1] emw,
                      input logic [0:15] ea0, input logic [0:15] ei0,
                      input logic [0:15] ea1, input logic [0:15] ei1,
                      input logic eerr, input logic ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; coreLoad = ld; coreWrite = wr;
    coreADDR0 = ca0; coreIN0 = cd0; coreADDR1 = ca1; coreIN1 = cd1;
    e.tag = tag; e.stall = es; e.ml = eml; e.mw = emw;
    e.a0 = ea0; e.i0 = ei0; e.a1 = ea1; e.i1 = ei1; e.err = eerr; e.cnt = ecnt;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, ".stall"},    32'(stall),    32'(e.stall));
      chk({e.tag, ".memLoad"},  32'(memLoad),  32'(e.ml));
      chk({e.tag, ".memWrite"}, 32'(memWrite), 32'(e.mw));
      chk({e.tag, ".memADDR0"}, 32'(memADDR0), 32'(e.a0));
      chk({e.tag, ".memIN0"},   32'(memIN0),   32'(e.i0));
      chk({e.tag, ".memADDR1"}, 32'(memADDR1), 32'(e.a1));
      chk({e.tag, ".memIN1"},   32'(memIN1),   32'(e.i1));
      chk({e.tag, ".errFlag"},  32'(errFlag),  32'(e.err));
      chk({e.tag, ".dual_write"}, 32'(memWrite == 2'b11), 32'd0);
      if (e.cnt) begin
        wr0_cnt += int'(memWrite[0]);
        wr1_cnt += int'(memWrite[1]);
      end
    end
  end

  initial begin
    //    tag    rst ld     wr     a0       d0       a1       d1       stall  ml     mw
    //           ea0      ei0      ea1      ei1      err cnt
    step("rst",  1, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 2'b00,
         16'h0, 16'h0, 16'h0, 16'h0, 0, 0);
    step("idle", 0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 2'b00,
         16'h0, 16'h0, 16'h0, 16'h0, 0, 0);
    // Private load on core0, private write on core1.
    step("priv", 0, 2'b10, 2'b01, 16'h0012, 16'h1111, 16'h0034, 16'hBEEF, 2'b00, 2'b00, 2'b00,
         16'h0, 16'h0, 16'h0, 16'h0, 0, 0);
    step("priv+1", 0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b10, 2'b01,
         16'h0012, 16'h1111, 16'h0034, 16'hBEEF, 0, 0);
    // Same shared address from both cores; core1 holds after its stall.
    step("shr", 0, 2'b00, 2'b11, 16'h0105, 16'hAAAA, 16'h0105, 16'h5555, 2'b01, 2'b00, 2'b00,
         16'h0012, 16'h1111, 16'h0034, 16'hBEEF, 0, 0);
    step("shr+1", 0, 2'b00, 2'b01, 16'h0, 16'h0, 16'h0105, 16'h5555, 2'b00, 2'b00, 2'b10,
         16'h0105, 16'hAAAA, 16'h0034, 16'hBEEF, 0, 0);
    step("shr+2", 0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 2'b01,
         16'h0105, 16'hAAAA, 16'h0105, 16'h5555, 0, 0);
    // Load and write together on core0.
    step("lw", 0, 2'b10, 2'b10, 16'h0007, 16'h7777, 16'h0, 16'h0, 2'b00, 2'b00, 2'b00,
         16'h0105, 16'hAAAA, 16'h0105, 16'h5555, 0, 0);
    step("lw+1", 0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 2'b10,
         16'h0007, 16'h7777, 16'h0105, 16'h5555, 1, 0);
    step("lw+2", 0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 2'b00,
         16'h0007, 16'h7777, 16'h0105, 16'h5555, 1, 0);
    // prio is 1 here, so core1 wins; then core0 wins; then reset with a pending conflict.
    step("cfA", 0, 2'b00, 2'b11, 16'h0100, 16'h0A0A, 16'h01FF, 16'h0B0B, 2'b10, 2'b00, 2'b00,
         16'h0007, 16'h7777, 16'h0105, 16'h5555, 1, 0);
    step("cfB", 0, 2'b00, 2'b11, 16'h0100, 16'h0A0A, 16'h0180, 16'h0C0C, 2'b01, 2'b00, 2'b01,
         16'h0007, 16'h7777, 16'h01FF, 16'h0B0B, 1, 0);
    step("cfRst", 1, 2'b00, 2'b11, 16'h0101, 16'h0D0D, 16'h0180, 16'h0C0C, 2'b00, 2'b00, 2'b10,
         16'h0100, 16'h0A0A, 16'h01FF, 16'h0B0B, 1, 0);
    // Continuous conflict after reset: core0 first, then alternating.
    step("cc1", 0, 2'b00, 2'b11, 16'h0110, 16'h1234, 16'h0120, 16'h4321, 2'b01, 2'b00, 2'b00,
         16'h0, 16'h0, 16'h0, 16'h0, 0, 1);
    step("cc2", 0, 2'b00, 2'b11, 16'h0110, 16'h1234, 16'h0120, 16'h4321, 2'b10, 2'b00, 2'b10,
         16'h0110, 16'h1234, 16'h0, 16'h0, 0, 1);
    for (int k = 3; k <= 6; k++) begin
      step($sformatf("cc%0d", k), 0, 2'b00, 2'b11, 16'h0110, 16'h1234, 16'h0120, 16'h4321,
           (k % 2 == 1) ? 2'b01 : 2'b10, 2'b00, (k % 2 == 1) ? 2'b01 : 2'b10,
           16'h0110, 16'h1234, 16'h0120, 16'h4321, 0, 1);
    end
    step("cc+1", 0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 2'b01,
         16'h0110, 16'h1234, 16'h0120, 16'h4321, 0, 1);
    step("cc+2", 0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 2'b00,
         16'h0110, 16'h1234, 16'h0120, 16'h4321, 0, 1);
    // Shared write on core0 alongside a private load on core1.
    step("mix", 0, 2'b01, 2'b10, 16'h0100, 16'hCAFE, 16'h0042, 16'h9999, 2'b00, 2'b00, 2'b00,
         16'h0110, 16'h1234, 16'h0120, 16'h4321, 0, 0);
    step("mix+1", 0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b01, 2'b10,
         16'h0100, 16'hCAFE, 16'h0042, 16'h9999, 0, 0);
    step("mix+2", 0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 2'b00,
         16'h0100, 16'hCAFE, 16'h0042, 16'h9999, 0, 0);

    repeat (4) @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("core0_strobes", 32'(wr0_cnt), 32'd3);
    chk("core1_strobes", 32'(wr1_cnt), 32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected end before 100000");
    $fatal(1);
  end

endmodule
